sfifo_16i_64o_512: RTL and testbench

Single-clock synchronous FIFO that accepts 16-bit words and delivers 64-bit words, four writes per read. It is the upsizing counterpart of the 64-bit-in / 16-bit-out asynchronous FIFO. It packs narrow streams, such as per-pixel convolution results, into 64-bit beats for the wide datapath and memory side. Flags and water levels use the same definitions as the existing FIFO IP, so it can be swapped in where both ends share one clock.

---
 rtl/sfifo_16i_64o_512.sv | 75 +++++++
 tb/tb_sfifo_16i_64o_512.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_16i_64o_512.sv
// Single-clock FIFO packing 16-bit writes into 64-bit reads, four lanes per word.
// Little-endian packing: the first write of a word lands in the low lane.
module sfifo_16i_64o_512 #(
    parameter int unsigned WR_DEPTH_WIDTH   = 9,
    parameter int unsigned WR_DATA_WIDTH    = 16,
    parameter int unsigned RD_DEPTH_WIDTH   = 7,
    parameter int unsigned RD_DATA_WIDTH    = 64,
    parameter int unsigned ALMOST_FULL_NUM  = 508,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      wr_en,
    output logic                      wr_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      almost_empty
);

    localparam int unsigned LANES    = RD_DATA_WIDTH / WR_DATA_WIDTH;
    localparam int unsigned LANE_W   = $clog2(LANES);
    localparam int unsigned RD_WORDS = 1 << RD_DEPTH_WIDTH;
    localparam int unsigned CAPACITY = 1 << WR_DEPTH_WIDTH;

    logic [LANES-1:0][WR_DATA_WIDTH-1:0] mem [RD_WORDS];

    logic [WR_DEPTH_WIDTH:0] wr_ptr;
    logic [RD_DEPTH_WIDTH:0] rd_ptr;
    logic [WR_DEPTH_WIDTH:0] wr_level;
    logic                    wr_accept;
    logic                    rd_accept;

    // Occupancy in lanes; the modulo subtraction keeps it correct across pointer wrap.
    assign wr_level       = wr_ptr - {rd_ptr, LANE_W'(0)};
    assign wr_water_level = wr_level;
    assign rd_water_level = wr_level[WR_DEPTH_WIDTH:LANE_W];

    assign wr_full      = (wr_level == (WR_DEPTH_WIDTH+1)'(CAPACITY));
    assign almost_full  = (wr_level >= (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM));
    assign rd_empty     = (rd_water_level == '0);
    assign almost_empty = (rd_water_level <= (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM));

    // Both acceptances use pre-edge flags, so a completing write never feeds a same-cycle read.
    assign wr_accept = wr_en && !wr_full;
    assign rd_accept = rd_en && !rd_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + (WR_DEPTH_WIDTH+1)'(1);
            end
            if (rd_accept) begin
                rd_ptr  <= rd_ptr + (RD_DEPTH_WIDTH+1)'(1);
                rd_data <= mem[rd_ptr[RD_DEPTH_WIDTH-1:0]];
            end
        end
    end

    // Lane write into the word addressed by the upper write-pointer bits.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr[WR_DEPTH_WIDTH-1:LANE_W]][wr_ptr[LANE_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sfifo_16i_64o_512.sv
// Scoreboard bench for sfifo_16i_64o_512: queue-of-lanes reference model, random and directed traffic.
module tb_sfifo_16i_64o_512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_full;
    logic [9:0]  wr_water_level;
    logic        almost_full;
    logic [63:0] rd_data;
    logic        rd_empty;
    logic [7:0]  rd_water_level;
    logic        almost_empty;

    always #5 clk = ~clk;

    sfifo_16i_64o_512 dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] mq[$];
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = '0;
    bit          rd_fired = 1'b0;
    bit          rst_fired = 1'b0;
    bit          checking = 1'b0;
    int          acc_wr = 0;
    int          acc_rd = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue of 16-bit words; a read takes four at once.
    always @(posedge clk) begin
        bit          do_rd;
        bit          do_wr;
        logic [63:0] w;
        rd_fired  = 1'b0;
        rst_fired = 1'b0;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            rst_fired = 1'b1;
        end else begin
            do_rd = rd_en && (mq.size() >= 4);
            do_wr = wr_en && (mq.size() < 512);
            if (do_rd) begin
                w = '0;
                for (int j = 0; j < 4; j++) w[16*j +: 16] = mq.pop_front();
                exp_q.push_back(w);
                rd_fired = 1'b1;
                acc_rd++;
            end
            if (do_wr) begin
                mq.push_back(wr_data);
                acc_wr++;
            end
        end
    end

    // Monitor: pops the expected word whenever a read completed, checks data and flags every cycle.
    always @(negedge clk) begin
        int sz;
        if (rst_fired) begin
            last_exp = '0;
        end else if (rd_fired) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else last_exp = exp_q.pop_front();
        end
        if (checking) begin
            sz = mq.size();
            check("mon_rd_data", rd_data, last_exp);
            check("mon_wr_level", 64'(wr_water_level), 64'(sz));
            check("mon_rd_level", 64'(rd_water_level), 64'(sz / 4));
            check("mon_wr_full", 64'(wr_full), 64'(sz == 512));
            check("mon_almost_full", 64'(almost_full), 64'(sz >= 508));
            check("mon_rd_empty", 64'(rd_empty), 64'(sz < 4));
            check("mon_almost_empty", 64'(almost_empty), 64'((sz / 4) <= 4));
        end
    end

    task automatic step(input logic r, input logic we, input logic [15:0] wd, input logic re);
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rd_empty"}, 64'(rd_empty), 64'd1);
        check({tag, "_almost_empty"}, 64'(almost_empty), 64'd1);
        check({tag, "_wr_full"}, 64'(wr_full), 64'd0);
        check({tag, "_almost_full"}, 64'(almost_full), 64'd0);
        check({tag, "_wr_level"}, 64'(wr_water_level), 64'd0);
        check({tag, "_rd_level"}, 64'(rd_water_level), 64'd0);
        check({tag, "_rd_data"}, rd_data, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        int          cyc;

        @(negedge clk);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        checking = 1'b1;
        reset_checks("por");

        // Random traffic then reset
        for (int i = 0; i < 60; i++)
            step(1'b0, 1'(($urandom % 4) != 0), 16'($urandom), 1'(($urandom % 3) == 0));
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        reset_checks("rst");

        // Basic pack
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        rd_en = 1'b0;
        check("pack_data", rd_data, 64'h0004_0003_0002_0001);
        check("pack_empty", 64'(rd_empty), 64'd1);
        check("pack_level", 64'(wr_water_level), 64'd0);

        // Partial word: read must be dropped
        for (int i = 5; i <= 7; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        check("part_wr_level", 64'(wr_water_level), 64'd3);
        check("part_rd_level", 64'(rd_water_level), 64'd0);
        check("part_empty", 64'(rd_empty), 64'd1);
        check("part_data_hold", rd_data, 64'h0004_0003_0002_0001);
        step(1'b0, 1'b1, 16'd8, 1'b0);
        check("part_complete", 64'(rd_empty), 64'd0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        check("part_data", rd_data, 64'h0008_0007_0006_0005);

        // Fill with a down-counter
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 1'b1, 16'hFFFF - 16'(i), 1'b0);
            check("fill_af", 64'(almost_full), 64'((i + 1) >= 508));
        end
        check("fill_full", 64'(wr_full), 64'd1);
        check("fill_wr_level", 64'(wr_water_level), 64'd512);
        check("fill_rd_level", 64'(rd_water_level), 64'd128);
        step(1'b0, 1'b1, 16'h1234, 1'b1);
        check("full_drop_level", 64'(wr_water_level), 64'd508);
        check("drain_first", rd_data, 64'hFFFC_FFFD_FFFE_FFFF);

        // Drain remaining words back to back
        for (int k = 1; k < 128; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            w = '0;
            for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(32'hFFFF - 32'(4*k + j));
            check("drain_data", rd_data, w);
            check("drain_ae", 64'(almost_empty), 64'((127 - k) <= 4));
        end
        rd_en = 1'b0;
        check("drain_empty", 64'(rd_empty), 64'd1);

        // Concurrent random stream across pointer wrap
        acc_wr = 0;
        acc_rd = 0;
        cyc = 0;
        while ((acc_wr < 2048 || acc_rd < 512) && cyc < 20000) begin
            step(1'b0, 1'((acc_wr < 2048) && (($urandom % 4) != 0)), 16'($urandom),
                 1'((acc_rd < 512) && (($urandom % 4) == 0)));
            cyc++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("stream_done", 64'(acc_wr >= 2048 && acc_rd >= 512), 64'd1);
        @(negedge clk);
        check("stream_empty", 64'(rd_empty), 64'd1);

        // Mid-operation reset at level 200
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        check("pre_rst_level", 64'(wr_water_level), 64'd200);
        step(1'b1, 1'b1, 16'hDEAD, 1'b1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        reset_checks("mid");
        step(1'b0, 1'b1, 16'hA001, 1'b0);
        step(1'b0, 1'b1, 16'hA002, 1'b0);
        step(1'b0, 1'b1, 16'hA003, 1'b0);
        step(1'b0, 1'b1, 16'hA004, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        rd_en = 1'b0;
        check("fresh_data", rd_data, 64'hA004_A003_A002_A001);
        @(negedge clk);
        check("final_empty", 64'(rd_empty), 64'd1);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
